// File: rtl/ddr_pkg.sv
// Shared DDR write-path types and constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the write-burst FSM state encoding, default lane width / burst
// length and the preamble / postamble lengths (one cycle each).
package ddr_pkg;

   localparam int DEF_BW        = 8;   // DQ byte-lane width in bits
   localparam int DEF_BL        = 8;   // burst length in DQ beats
   localparam int PREAMBLE_CYC  = 1;   // DQS driven low before the first beat
   localparam int POSTAMBLE_CYC = 1;   // DQS driven low after the last beat

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PREAMBLE  = 2'd1,
      BURST     = 2'd2,
      POSTAMBLE = 2'd3
   } wb_state_t;

endpackage

// File: rtl/ddr_out_mux.sv
// DDR output mux: drives the high half of a registered word while clock=1, the low half while clock=0.
// Latency: combinational from din and clock level.
// Backpressure: none; output forced to zero when en=0.
//
// Ports: clock (half select), en (drive enable), din[2*W-1:0] (word), dout[W-1:0] (beat).
module ddr_out_mux #(
   parameter int W = 8
) (
   input  logic           clock,
   input  logic           en,
   input  logic [2*W-1:0] din,
   output logic [W-1:0]   dout
);

   always_comb begin
      dout = '0;
      if (en) begin
         dout = clock ? din[2*W-1:W] : din[W-1:0];
      end
   end

endmodule

// File: rtl/write_burst.sv
// DDR write burst sequencer: preamble, BL/2 words as BL DDR beats, postamble.
// Latency: word accepted at edge k is driven on DQ during cycle k+1 (high half first).
// Backpressure: wr_ready from registered state only; a missing word zero-fills its beats and flags underrun.
//
// Ports:
//   clock, reset_n          single clock, async active-low reset
//   wr_valid/wr_data/wr_ready  write word handshake; wr_data[2*BW-1:BW] is the rising-half beat
//   dq_out, dq_oe           DDR data and its enable (BURST only)
//   dqs_out, dqs_oe         data strobe (edge-aligned, follows clock in BURST) and its enable
//   busy                    FSM not in IDLE
//   underrun                one-cycle pulse, a required word was missing
//   wr_mask, dm_out         data-mask path, present only with WRITE_BURST_DM_EN defined
module write_burst
   import ddr_pkg::*;
#(
   parameter int BW = DEF_BW,
   parameter int BL = DEF_BL
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          wr_valid,
   input  logic [2*BW-1:0] wr_data,
`ifdef WRITE_BURST_DM_EN
   input  logic [1:0]    wr_mask,
   output logic [0:0]    dm_out,
`endif
   output logic          wr_ready,
   output logic [BW-1:0] dq_out,
   output logic          dq_oe,
   output logic          dqs_out,
   output logic          dqs_oe,
   output logic          busy,
   output logic          underrun
);

   localparam int WPB = BL / 2;                 // words per burst
   localparam int CW  = $clog2(WPB);
   localparam logic [CW-1:0] LAST = CW'(WPB - 1);

   wb_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*BW-1:0] data_q, data_d;
   logic            underrun_q, underrun_d;
   logic            take;
   logic            starve;
   logic            in_burst;

`ifdef WRITE_BURST_DM_EN
   logic [1:0]      mask_q, mask_d;
`endif

   // The last BURST cycle has no successor word inside this burst, so the
   // controller is only asked for BL/2 words: one in PREAMBLE, the rest in BURST.
   assign wr_ready = (state_q == PREAMBLE) || ((state_q == BURST) && (cnt_q != LAST));
   assign take     = wr_ready && wr_valid;
   assign starve   = wr_ready && !wr_valid;
   assign in_burst = (state_q == BURST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (wr_valid) state_d = PREAMBLE;
         end
         PREAMBLE: begin
            state_d = BURST;
            cnt_d   = '0;
         end
         BURST: begin
            if (cnt_q == LAST) begin
               state_d = POSTAMBLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         POSTAMBLE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // A missing word still occupies its beat slot: send zeros rather than
   // repeating stale data, and keep the burst length intact.
   always_comb begin
      data_d     = data_q;
      underrun_d = starve;
      if (take) begin
         data_d = wr_data;
      end else if (starve) begin
         data_d = '0;
      end
   end

`ifdef WRITE_BURST_DM_EN
   // Underrun beats are masked so the DRAM ignores the zero fill.
   always_comb begin
      mask_d = mask_q;
      if (take) begin
         mask_d = wr_mask;
      end else if (starve) begin
         mask_d = 2'b11;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         data_q     <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         underrun_q <= underrun_d;
      end
   end

   ddr_out_mux #(.W(BW)) u_dq_mux (
      .clock (clock),
      .en    (in_burst),
      .din   (data_q),
      .dout  (dq_out)
   );

`ifdef WRITE_BURST_DM_EN
   ddr_out_mux #(.W(1)) u_dm_mux (
      .clock (clock),
      .en    (in_burst),
      .din   (mask_q),
      .dout  (dm_out)
   );
`endif

   // Strobe is edge-aligned with data; the PHY adds the quarter-cycle shift.
   assign dq_oe    = in_burst;
   assign dqs_out  = in_burst & clock;
   assign dqs_oe   = (state_q != IDLE);
   assign busy     = (state_q != IDLE);
   assign underrun = underrun_q;

endmodule

// File: tb/tb_write_burst.sv
module tb_write_burst;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b1;
   logic        wr_valid;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic [7:0]  dq_out;
   logic        dq_oe, dqs_out, dqs_oe, busy, underrun;

   // second instance at BL=4
   logic        v4_valid;
   logic [15:0] v4_data;
   logic        r4_ready;
   logic [7:0]  r4_dq;
   logic        r4_dq_oe, r4_dqs, r4_dqs_oe, r4_busy, r4_underrun;

`ifdef WRITE_BURST_DM_EN
   logic [1:0]  wr_mask;
   logic [0:0]  dm_out;
   logic [1:0]  v4_mask;
   logic [0:0]  r4_dm;
`endif

   always #5 clock = ~clock;

   write_burst #(.BW(8), .BL(8)) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
`ifdef WRITE_BURST_DM_EN
      .wr_mask  (wr_mask),
      .dm_out   (dm_out),
`endif
      .wr_ready (wr_ready),
      .dq_out   (dq_out),
      .dq_oe    (dq_oe),
      .dqs_out  (dqs_out),
      .dqs_oe   (dqs_oe),
      .busy     (busy),
      .underrun (underrun)
   );

   write_burst #(.BW(8), .BL(4)) u_bl4 (
      .clock    (clock),
      .reset_n  (reset_n),
      .wr_valid (v4_valid),
      .wr_data  (v4_data),
`ifdef WRITE_BURST_DM_EN
      .wr_mask  (v4_mask),
      .dm_out   (r4_dm),
`endif
      .wr_ready (r4_ready),
      .dq_out   (r4_dq),
      .dq_oe    (r4_dq_oe),
      .dqs_out  (r4_dqs),
      .dqs_oe   (r4_dqs_oe),
      .busy     (r4_busy),
      .underrun (r4_underrun)
   );

   int tests = 0;
   int fails = 0;
   int und_cnt = 0;
   int bst_run = 0;
   int amb_run = 0;
   logic prev_pre = 1'b0;
   logic [8:0] exp_q[$];   // {dm, dq} per beat, in beat order

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] w, input logic [1:0] m);
      exp_q.push_back({m[1], w[15:8]});
      exp_q.push_back({m[0], w[7:0]});
   endtask

   task automatic pop_cmp(input string nm);
      logic [8:0] e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: got beat %0h expected no beat (scoreboard empty)", nm, dq_out);
      end else begin
         e = exp_q.pop_front();
         chk(nm, dq_out, e[7:0]);
`ifdef WRITE_BURST_DM_EN
         chk({nm, "_dm"}, dm_out, e[8]);
`endif
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the word was taken.
   task automatic send(input logic [15:0] d, input logic [1:0] m, output int waits);
      waits = 0;
      push_word(d, m);
      wr_valid = 1'b1;
      wr_data  = d;
`ifdef WRITE_BURST_DM_EN
      wr_mask  = m;
`endif
      while (!wr_ready && waits < 50) begin
         @(negedge clock);
         waits++;
      end
      if (waits >= 50) begin
         tests++;
         fails++;
         $display("FAIL handshake_timeout: got wr_ready 0 for %0d cycles expected 1", waits);
      end
      @(negedge clock);
   endtask

   // Monitor, high half of each cycle.
   always @(posedge clock) begin
      #2;
      if (!reset_n) begin
         bst_run  = 0;
         amb_run  = 0;
         prev_pre = 1'b0;
      end else begin
         if (dq_oe) begin
            if (bst_run == 0) chk("preamble_before_data", prev_pre, 1);
            bst_run++;
            chk("dqs_hi_half", dqs_out, 1);
            pop_cmp("beat_hi");
         end else begin
            chk("dq_outside_burst", dq_out, 0);
            if (bst_run != 0) begin
               chk("burst_cycles", bst_run, 4);
               bst_run = 0;
            end
         end
         if (dqs_oe && !dq_oe) begin
            chk("amble_dqs_low", dqs_out, 0);
            amb_run++;
         end else if (amb_run != 0) begin
            chk("amble_cycles", amb_run, 1);
            amb_run = 0;
         end
         prev_pre = dqs_oe && !dq_oe;
         if (underrun) und_cnt++;
      end
   end

   // Monitor, low half of each cycle.
   always @(negedge clock) begin
      #2;
      if (reset_n && dq_oe) begin
         chk("dqs_lo_half", dqs_out, 0);
         pop_cmp("beat_lo");
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000 expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int u0;
      int r4, o4, q4, a4, n4;
      logic [15:0] b2b [8];
      int          b2b_wait [8];

      b2b      = '{16'h0102, 16'h0304, 16'h0506, 16'h0708,
                   16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10};
      b2b_wait = '{1, 0, 0, 0, 3, 0, 0, 0};

      reset_n  = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;
      v4_valid = 1'b0;
      v4_data  = '0;
`ifdef WRITE_BURST_DM_EN
      wr_mask  = '0;
      v4_mask  = '0;
`endif
      #1;
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_oe", {dq_oe, dqs_oe}, 0);
      chk("rst_dqs_dq", {dqs_out, dq_out}, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_bl4_ready_busy", {r4_ready, r4_busy}, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      // single burst
      u0 = und_cnt;
      send(16'hA1B2, 2'b00, w);
      chk("t1_first_wait", w, 1);
      send(16'hC3D4, 2'b00, w);
      send(16'hE5F6, 2'b00, w);
      send(16'h0718, 2'b00, w);
      wr_valid = 1'b0;
      repeat (4) @(negedge clock);
      chk("t1_drain", exp_q.size(), 0);
      chk("t1_underrun", und_cnt - u0, 0);
      chk("t1_idle", busy, 0);

      // third word withheld
      u0 = und_cnt;
      send(16'hA1B2, 2'b00, w);
      send(16'hC3D4, 2'b00, w);
      wr_valid = 1'b0;
      push_word(16'h0000, 2'b11);
      @(negedge clock);
      send(16'h0718, 2'b00, w);
      wr_valid = 1'b0;
      repeat (4) @(negedge clock);
      chk("t2_drain", exp_q.size(), 0);
      chk("t2_underrun_pulses", und_cnt - u0, 1);
      chk("t2_idle", busy, 0);

      // reset in BURST with counter = 1
      send(16'h1111, 2'b00, w);
      send(16'h2222, 2'b00, w);
      #3;
      reset_n  = 1'b0;
      wr_valid = 1'b0;
      #1;
      chk("t3_rst_ready_busy", {wr_ready, busy}, 0);
      chk("t3_rst_oe", {dq_oe, dqs_oe}, 0);
      chk("t3_rst_dq_dqs_und", {dq_out, dqs_out, underrun}, 0);
      @(posedge clock);
      #3;
      chk("t3_rst_hi_half", {dq_out, dqs_out, dqs_oe, dq_oe}, 0);
      @(negedge clock);
      reset_n = 1'b1;
      chk("t3_drain_before", exp_q.size(), 0);
      u0 = und_cnt;
      send(16'h3344, 2'b00, w);
      chk("t3_fresh_wait", w, 1);
      send(16'h5566, 2'b00, w);
      send(16'h7788, 2'b00, w);
      send(16'h99AA, 2'b00, w);
      wr_valid = 1'b0;
      repeat (4) @(negedge clock);
      chk("t3_drain_after", exp_q.size(), 0);
      chk("t3_underrun", und_cnt - u0, 0);

      // back-to-back, eight words
      for (int i = 0; i < 8; i++) begin
         send(b2b[i], 2'b00, w);
         chk($sformatf("t4_wait_%0d", i), w, b2b_wait[i]);
      end
      wr_valid = 1'b0;
      repeat (4) @(negedge clock);
      chk("t4_drain", exp_q.size(), 0);
      chk("t4_idle", busy, 0);

      // mask path (dm compared by the monitor when present)
      send(16'h55AA, 2'b01, w);
      send(16'h6677, 2'b00, w);
      send(16'h8899, 2'b10, w);
      send(16'hBBCC, 2'b00, w);
      wr_valid = 1'b0;
      repeat (4) @(negedge clock);
      chk("t5_drain", exp_q.size(), 0);

      // BL=4 instance
      r4 = 0; o4 = 0; q4 = 0; a4 = 0; n4 = 0;
      v4_data  = 16'h1234;
      v4_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (a4 == 2) v4_valid = 1'b0;
         if (r4_ready) r4++;
         if (r4_dqs_oe) q4++;
         if (r4_underrun) n4++;
         if (r4_dq_oe) begin
            o4++;
            chk("t6_dq_lo", r4_dq, 8'h34);
            chk("t6_dqs_lo", r4_dqs, 0);
`ifdef WRITE_BURST_DM_EN
            chk("t6_dm_lo", r4_dm, 0);
`endif
         end
         if (r4_ready && v4_valid) a4++;
      end
      chk("t6_ready_cycles", r4, 2);
      chk("t6_burst_cycles", o4, 2);
      chk("t6_dqs_oe_cycles", q4, 4);
      chk("t6_underrun", n4, 0);
      chk("t6_idle", r4_busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/write_burst.md
WRITE_BURST -- requirements
Module: write_burst

Interface
REQ-001 Parameter BW, default 8, DQ byte-lane width in bits.
REQ-002 Parameter BL, default 8, burst length in DQ beats; SHALL be even and >= 4. Words per burst: BL/2.
REQ-003 clock  input  1  single clock; rising edge is the only register clock edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 wr_valid  input  1  controller offers a write word.
REQ-006 wr_data  input  2*BW  write word; [2*BW-1:BW] goes on the rising-half beat, [BW-1:0] on the falling-half beat.
REQ-007 wr_ready  output  1  block accepts wr_data this cycle.
REQ-008 dq_out  output  BW  DDR data to DRAM.
REQ-009 dq_oe  output  1  DQ output enable.
REQ-010 dqs_out  output  1  data strobe.
REQ-011 dqs_oe  output  1  DQS output enable.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 underrun  output  1  one-cycle pulse: a required word was missing.

Function
REQ-014 FSM states: IDLE, PREAMBLE, BURST, POSTAMBLE; the state and a beat counter of width $clog2(BL/2) are registered.
REQ-015 IDLE -> PREAMBLE when wr_valid=1; wr_ready=0 in IDLE, so that word is not consumed yet.
REQ-016 PREAMBLE -> BURST after exactly 1 cycle; counter cleared to 0.
REQ-017 BURST lasts exactly BL/2 cycles; counter increments each cycle; on counter == BL/2-1 -> POSTAMBLE.
REQ-018 POSTAMBLE -> IDLE after exactly 1 cycle; minimum gap between bursts is IDLE + PREAMBLE.
REQ-019 wr_ready = (state==PREAMBLE) or (state==BURST and counter != BL/2-1); combinational from registered state only, never from wr_valid.
REQ-020 Handshake: a word transfers at a rising edge where wr_valid=1 and wr_ready=1; it is captured into data_q.
REQ-021 Latency: a word accepted at edge k is driven during cycle k+1; dq_out = data_q[2*BW-1:BW] while clock=1, data_q[BW-1:0] while clock=0.
REQ-022 dq_oe = 1 and dqs_oe = 1 throughout BURST; dqs_oe = 1 and dqs_out = 0 in PREAMBLE and POSTAMBLE; all enables = 0 in IDLE.
REQ-023 In BURST, dqs_out equals the clock level (edge-aligned); the PHY applies the 90-degree shift.
REQ-024 Underrun: if wr_ready=1 and wr_valid=0 in PREAMBLE or BURST, then data_q <= 0, underrun pulses in the next cycle, and the burst still runs for its full BL beats.
REQ-025 Outside BURST, dq_out = 0.

Reset
REQ-026 reset_n=0, including mid-burst, SHALL immediately force:
- state = IDLE, counter = 0, data_q = 0;
- wr_ready = 0, dq_oe = 0, dqs_oe = 0, dqs_out = 0, dq_out = 0, busy = 0, underrun = 0.
REQ-027 After reset_n rises, the block waits in IDLE for wr_valid; no partial burst resumes.

Configuration
REQ-028 Macro WRITE_BURST_DM_EN defined: adds input wr_mask[1:0] and output dm_out[0:0].
- wr_mask is captured with wr_data.
- dm_out = mask[1] while clock=1 and mask[0] while clock=0 during BURST.
- dm_out = 0 otherwise.
- Underrun forces the captured mask to 2'b11, so the missing beats are masked.
REQ-029 Macro not defined: no mask ports and no mask register; all other behaviour is identical.

Structure
REQ-030 Shared package ddr_pkg holds:
- the state enum wb_state_t {IDLE, PREAMBLE, BURST, POSTAMBLE};
- the default BW/BL constants;
- the PREAMBLE_CYC=1 and POSTAMBLE_CYC=1 constants.
REQ-031 One sub-module, ddr_out_mux: selects the high or low half by clock level; used for both dq_out and dm_out.

Verification
REQ-032 Single burst, BL=8: wr_valid held 1 with words 16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718.
- dq_out sequence A1,B2,C3,D4,E5,F6,07,18 over 4 BURST cycles.
- Preamble and postamble each last 1 cycle; underrun stays 0.
REQ-033 Gap: wr_valid low at the 3rd ready cycle (third word 16'hE5F6 withheld).
- underrun pulses once.
- Beats 5-6 read 00,00; the burst completes 8 beats; the FSM returns to IDLE.
REQ-034 Reset mid-burst: reset_n low during BURST counter=1.
- All outputs are 0 in the same delta.
- After release with wr_valid=1, a fresh preamble occurs before any data.
REQ-035 Back-to-back: wr_valid held high for 8 words.
- Two bursts separated by POSTAMBLE, IDLE, PREAMBLE.
- wr_ready is low for exactly 3 cycles between bursts; data order is preserved.
REQ-036 WRITE_BURST_DM_EN: word 16'h55AA with wr_mask 2'b01 -> dm_out 0 on the rising half and 1 on the falling half; the same test with the macro undefined compiles with no dm port.
REQ-037 BL=4 parameter run: BURST lasts exactly 2 cycles; wr_ready is high for PREAMBLE plus 1 BURST cycle.
